// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter between NUM_REQ byte producers.
// It latches the winning channel's byte and runs the tx_req/tx_ack handshake with an optional ack timeout.
module serial_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_BITS    = 8,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            ch_valid,
    input  logic [NUM_REQ*NUM_BITS-1:0]   ch_data,
    output logic [NUM_REQ-1:0]            ch_done,
    output logic [NUM_REQ-1:0]            ch_err,
    output logic                          tx_req,
    output logic [NUM_BITS-1:0]           tx_data,
    input  logic                          tx_ack,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST   = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_grant;
    logic [TW-1:0]         r_timer;
    logic                  r_tx_req;
    logic [NUM_BITS-1:0]   r_tx_data;
    logic [NUM_REQ-1:0]    r_done;
    logic [NUM_REQ-1:0]    r_err;
    logic                  r_busy;

    logic [NUM_BITS-1:0]   w_ch_data [NUM_REQ];
    logic                  w_any;
    logic [IW-1:0]         w_pick;
    logic [IW:0]           w_sum;
    logic [IW-1:0]         w_next_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_ch_data[gi] = ch_data[gi*NUM_BITS +: NUM_BITS];
        end
    endgenerate

    // Scan from the highest offset down so the channel closest to r_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        w_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            if (ch_valid[w_sum[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IW-1:0];
            end
        end
    end

    assign w_next_ptr = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_timer   <= '0;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_pick;
                        r_tx_data <= w_ch_data[w_pick];
                        r_tx_req  <= 1'b1;
                        r_timer   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tx_ack) begin
                        r_tx_req         <= 1'b0;
                        r_done[r_grant]  <= 1'b1;
                        r_state          <= WAIT_LOW;
                    end else if ((ACK_TIMEOUT != 0) && (r_timer == TLAST)) begin
                        r_tx_req        <= 1'b0;
                        r_err[r_grant]  <= 1'b1;
                        r_ptr           <= w_next_ptr;
                        r_busy          <= 1'b0;
                        r_state         <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    // Holding off the next grant until ack falls keeps one ack per byte.
                    if (!tx_ack) begin
                        r_ptr   <= w_next_ptr;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ch_done  = r_done;
    assign ch_err   = r_err;
    assign tx_req   = r_tx_req;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: directed vector table, async reset and
// withdraw sequences, then randomized producers checked against a round-robin reference model.
module tb_serial_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TO    = 16;
    localparam int NOACK = 99;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   ch_valid = '0;
    logic [N*W-1:0] ch_data = '0;
    logic [N-1:0]   ch_done;
    logic [N-1:0]   ch_err;
    logic           tx_req;
    logic [W-1:0]   tx_data;
    logic           tx_ack = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .NUM_REQ     (N),
        .NUM_BITS    (W),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_done  (ch_done),
        .ch_err   (ch_err),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data;
        int         ack_dly;
        int         exp_id;
        bit         exp_err;
        bit         withdraw;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requesting channel at or after ptr, modulo N.
    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_vec(input vec_t v);
        int  cyc;
        int  nreq;
        bit  got;
        bit  hold_bad;
        int  exp_cyc;
        ch_valid = v.valid;
        for (int i = 0; i < N; i++) ch_data[i*W +: W] = (i == v.exp_id) ? v.data : ~v.data;
        @(posedge clk); #1;
        check("grant_req", tx_req, 1);
        check("grant_id", grant_id, v.exp_id);
        check("grant_data", tx_data, v.data);
        check("grant_busy", busy, 1);
        if (v.withdraw) ch_valid = '0;
        cyc = 0; nreq = 1; got = 0; hold_bad = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (k == v.ack_dly) tx_ack = 1'b1;
            @(posedge clk); #1;
            cyc = k + 1;
            if (ch_done != '0 || ch_err != '0) got = 1;
            else if (tx_req) begin
                nreq++;
                if (tx_data !== v.data) hold_bad = 1;
            end
        end
        exp_cyc = v.exp_err ? TO : v.ack_dly + 1;
        check("outcome_seen", got, 1);
        check("done_vec", ch_done, v.exp_err ? 0 : (1 << v.exp_id));
        check("err_vec", ch_err, v.exp_err ? (1 << v.exp_id) : 0);
        check("latency", cyc, exp_cyc);
        check("req_cycles", nreq, exp_cyc);
        check("data_hold", hold_bad, 0);
        ch_valid = '0;
        @(posedge clk); #1;
        tx_ack = 1'b0;
        check("pulse_one_cycle", {ch_done, ch_err}, 0);
        for (int k = 0; k < 6 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("back_idle", busy, 0);
        nreq = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (tx_req) nreq++;
        end
        check("no_dup_frame", nreq, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0] pv;
        logic [7:0] pd [N];
        logic [3:0] just;
        int  mptr, tid, age, adly, ahold;
        bit  in_txn, prev_req;
        int  n_ok, n_to;

        //          valid    data   ack_dly exp err wd
        tbl[0]  = '{4'b0100, 8'hA5, 3,      2,  0,  0};
        tbl[1]  = '{4'b1001, 8'h3C, 0,      3,  0,  0};
        tbl[2]  = '{4'b1001, 8'hC3, 5,      0,  0,  0};
        tbl[3]  = '{4'b1111, 8'h11, 1,      1,  0,  0};
        tbl[4]  = '{4'b1111, 8'h22, 1,      2,  0,  0};
        tbl[5]  = '{4'b1111, 8'h33, 1,      3,  0,  0};
        tbl[6]  = '{4'b1111, 8'h44, 1,      0,  0,  0};
        tbl[7]  = '{4'b0010, 8'h5A, NOACK,  1,  1,  0};
        tbl[8]  = '{4'b0110, 8'h66, TO-1,   2,  0,  0};
        tbl[9]  = '{4'b0011, 8'h77, 2,      0,  0,  0};
        tbl[10] = '{4'b0001, 8'h88, 0,      0,  0,  1};
        tbl[11] = '{4'b1010, 8'h99, 4,      1,  0,  0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {ch_done, ch_err}, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_data", tx_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 12; t++) do_vec(tbl[t]);

        // Async reset in the middle of ISSUE; ptr would otherwise point at ch0 after ch3.
        ch_valid = 4'b1000;
        ch_data  = {8'hE1, 8'h00, 8'h00, 8'h00};
        @(posedge clk); #1;
        check("rstmid_grant", {tx_req, grant_id}, {1'b1, 2'd3});
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_async_req_busy", {tx_req, busy}, 0);
        check("rstmid_async_done_err", {ch_done, ch_err}, 0);
        ch_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_vec('{4'b1111, 8'h5C, 2, 0, 0, 0});

        // Randomized producers against the reference model.
        mptr = 1; pv = '0; in_txn = 0; prev_req = 0; tx_ack = 1'b0;
        n_ok = 0; n_to = 0; tid = 0; age = 0; adly = 0; ahold = 0;
        for (int i = 0; i < N; i++) pd[i] = '0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            just = '0;
            if (!in_txn && tx_req && !prev_req) begin
                tid = rr_pick(mptr, pv);
                if (tid < 0) begin
                    check("rnd_spurious_grant", tx_req, 0);
                end else begin
                    check("rnd_grant_id", grant_id, tid);
                    check("rnd_tx_data", tx_data, pd[tid]);
                    in_txn = 1; age = 0;
                    mptr = (tid + 1) % N;
                    if ($urandom_range(0, 4) == 0) adly = -1;
                    else adly = int'($urandom_range(0, TO - 1));
                end
            end else if (in_txn) begin
                age++;
            end
            if (in_txn) begin
                if (ch_done != '0 || ch_err != '0) begin
                    check("rnd_done", ch_done, (adly < 0) ? 0 : (1 << tid));
                    check("rnd_err", ch_err, (adly < 0) ? (1 << tid) : 0);
                    check("rnd_latency", age, (adly < 0) ? TO : adly + 1);
                    if (adly < 0) n_to++;
                    else n_ok++;
                    pv[tid] = 1'b0; just[tid] = 1'b1; in_txn = 0;
                    ahold = int'($urandom_range(0, 2));
                end else if (age > TO + 2) begin
                    n_vec++; n_bad++;
                    $display("FAIL rnd_outcome_seen: no done/err after %0d cycles, ch %0d", age, tid);
                    in_txn = 0; pv = '0; tx_ack = 1'b0;
                end else if (tx_req !== 1'b1 || tx_data !== pd[tid]) begin
                    n_vec++; n_bad++;
                    $display("FAIL rnd_req_hold: got req=%0b data=%0h expected req=1 data=%0h",
                             tx_req, tx_data, pd[tid]);
                end
            end else if (ch_done != '0 || ch_err != '0) begin
                n_vec++; n_bad++;
                $display("FAIL rnd_stray_pulse: got done=%0h err=%0h expected 0", ch_done, ch_err);
            end
            if (in_txn && adly >= 0 && age == adly) tx_ack = 1'b1;
            else if (!in_txn && tx_ack) begin
                if (ahold == 0) tx_ack = 1'b0;
                else ahold--;
            end
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && !just[i] && $urandom_range(0, 3) == 0) begin
                    pd[i] = 8'($urandom);
                    pv[i] = 1'b1;
                end
                ch_data[i*W +: W] = pd[i];
            end
            ch_valid = pv;
            prev_req = tx_req;
        end
        tx_ack = 1'b0;
        check("rnd_enough_done", n_ok > 20, 1);
        check("rnd_some_timeout", n_to > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
